// File: rtl/fifo_rd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_rd_sched
// Purpose  : Round-robin read scheduler that bursts FIFO pops to one consumer
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_sched #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       rclk,
    input  logic                       rrst_n,
    input  logic                       empty,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       r_en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           out_ready,
    output logic [N_REQ-1:0]           gnt,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(N_REQ)-1:0]   out_sel
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam int BW    = $clog2(MAX_BURST) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [SEL_W-1:0] r_owner;
    logic [SEL_W-1:0] r_last;
    logic [BW-1:0]    r_beat;
    logic [BW-1:0]    w_beat_inc;
    logic [SEL_W-1:0] w_win;
    logic             w_found;
    int               w_idx;
    logic             w_accept;
    logic             w_last_beat;
    logic             w_arb;
    logic             w_drain_exit;

    // Winner: first requester scanning upward from the previous owner + 1.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(r_last) + i) % N_REQ;
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx[SEL_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_accept     = out_valid & out_ready[out_sel];
    assign w_beat_inc   = r_beat + 1'b1;
    assign w_last_beat  = r_en & (w_beat_inc == BW'(MAX_BURST));
    assign w_arb        = (r_state == S_IDLE) & (|req) & ~empty;
    assign w_drain_exit = (r_state == S_DRAIN) & (~out_valid | w_accept);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arb) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[r_owner] || w_last_beat || (r_beat >= BW'(MAX_BURST))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_exit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pop only when the output register is free or being drained this cycle.
    always_comb begin
        gnt  = '0;
        r_en = 1'b0;
        if ((r_state == S_GRANT) || (r_state == S_DRAIN)) begin
            gnt[r_owner] = 1'b1;
        end
        if (r_state == S_GRANT) begin
            r_en = req[r_owner] & ~empty & (~out_valid | out_ready[r_owner]);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_owner <= '0;
            r_last  <= SEL_W'(N_REQ - 1);
            r_beat  <= '0;
        end else begin
            if (w_arb) begin
                r_owner <= w_win;
            end
            if (w_drain_exit) begin
                r_last <= r_owner;
                r_beat <= '0;
            end else if (r_en) begin
                r_beat <= w_beat_inc;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (r_en) begin
            out_valid <= 1'b1;
            out_data  <= rdata;
            out_sel   <= r_owner;
        end else if (w_accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_sched.md
FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of read consumers (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning FIFO word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum pops per grant (1..16).
REQ-004 SHALL have port rclk, input, 1, read-domain clock; all state on rising edge.
REQ-005 SHALL have port rrst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port empty, input, 1, FIFO read-side empty flag.
REQ-007 SHALL have port rdata, input, DATA_WIDTH, FIFO head word, valid combinationally in the pop cycle.
REQ-008 SHALL have port r_en, output, 1, FIFO pop strobe.
REQ-009 SHALL have port req, input, N_REQ, per-consumer read request.
REQ-010 SHALL have port out_ready, input, N_REQ, per-consumer accept.
REQ-011 SHALL have port gnt, output, N_REQ, one-hot current owner, zero when no owner.
REQ-012 SHALL have port out_valid, output, 1, output register holds a word.
REQ-013 SHALL have port out_data, output, DATA_WIDTH, registered popped word.
REQ-014 SHALL have port out_sel, output, clog2(N_REQ), consumer index owning out_data.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, DRAIN; gnt nonzero only in GRANT and DRAIN.
REQ-016 IDLE: at an edge with (|req) and !empty, SHALL load owner = round-robin winner and enter GRANT; otherwise stay in IDLE.
REQ-017 Round-robin winner SHALL be the first requester set, searching upward from last+1 modulo N_REQ.
REQ-018 r_en SHALL equal (state==GRANT) & req[owner] & !empty & (!out_valid | out_ready[owner]), combinationally.
REQ-019 r_en SHALL never assert while empty=1; no underflow pop is possible.
REQ-020 On an r_en cycle, SHALL register out_data<=rdata, out_valid<=1, out_sel<=owner, and increment beat count.
REQ-021 out_valid SHALL clear on an edge with out_ready[out_sel]=1 and no pop in that cycle; a simultaneous pop and accept SHALL keep out_valid=1 with the new word.
REQ-022 GRANT->DRAIN SHALL occur on the edge where beat count reaches MAX_BURST or req[owner]=0; empty alone SHALL NOT end a grant.
REQ-023 DRAIN->IDLE SHALL occur when out_valid=0 or when out_valid is accepted that cycle; last<=owner and beat count<=0 on exit.
REQ-024 Beat count SHALL be clog2(MAX_BURST)+1 bits and never exceed MAX_BURST.
REQ-025 Latency SHALL be: req to gnt = 1 cycle; gnt to first r_en = 0 cycles when !empty; r_en to out_valid = 1 cycle.
REQ-026 Owner change SHALL never occur while out_valid=1; words SHALL never be delivered to a non-owner.
REQ-027 Requests arriving during GRANT/DRAIN SHALL be held off until the next IDLE arbitration.

Reset
REQ-028 On rrst_n=0, SHALL immediately force state=IDLE, gnt=0, r_en=0, out_valid=0, out_data=0, out_sel=0, beat count=0, last=N_REQ-1.
REQ-029 Reset mid-burst SHALL discard a held out_data word; it SHALL NOT be re-popped.
REQ-030 After rrst_n deasserts, first arbitration SHALL favour requester 0.

Verification
REQ-031 Reset then req=4'b1111, empty=0, out_ready=1111 -> gnt order 0001,0010,0100,1000, 4 pops each, 1 IDLE cycle between grants.
REQ-032 req=4'b0100, out_ready=0 with 1 word popped -> r_en stays 0, out_valid=1 held; out_ready[2]=1 -> next pop same cycle.
REQ-033 Grant to consumer 1, empty=1 after 2 pops -> r_en=0, gnt holds 0010; empty=0 -> pops 3,4 then DRAIN.
REQ-034 Consumer 3 drops req after 1 pop, out_valid=1, out_ready=0 -> DRAIN holds gnt=1000 until accept, then IDLE.
REQ-035 Assert rrst_n=0 mid-burst with out_valid=1 -> all outputs 0 asynchronously; after release, req=1111 -> gnt=0001.
REQ-036 Random req/out_ready/empty soak -> no r_en while empty, gnt one-hot or zero, word count out equals pops.
